// File: rtl/time_counter.sv
// time_counter: time-of-day keeper fed by the timing_generator strobes.
// Holds HH:MM as four BCD digits, steps on the selected advance strobe,
// accepts validated time loads and emits registered hour/day/error pulses.
// Optional feature: define TWELVE_HOUR_EN for 12-hour mode with a pm output.
module time_counter #(
  parameter logic [7:0] RESET_HR  = 8'h00,
  parameter logic [7:0] RESET_MIN = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        one_second,
  input  logic        one_minute,
  input  logic        fast_watch,
  input  logic        load_new_time,
  input  logic [15:0] new_time,
  output logic [15:0] current_time,
  output logic        hour_tick,
  output logic        day_tick,
`ifdef TWELVE_HOUR_EN
  output logic        pm,
`endif
  output logic        load_error
);

`ifdef TWELVE_HOUR_EN
  localparam logic [7:0] INIT_HR = 8'h12;
`else
  localparam logic [7:0] INIT_HR = RESET_HR;
`endif

  logic [15:0] time_q;
  logic [15:0] time_d;
  logic        hour_tick_d;
  logic        day_tick_d;
  logic        load_error_d;
  logic        pm_q;
  logic        pm_d;
  logic        adv;
  logic        load_ok;

  logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
  logic [3:0] nt_ms_hr, nt_ls_hr, nt_ms_min, nt_ls_min;

  assign ms_hr     = time_q[15:12];
  assign ls_hr     = time_q[11:8];
  assign ms_min    = time_q[7:4];
  assign ls_min    = time_q[3:0];
  assign nt_ms_hr  = new_time[15:12];
  assign nt_ls_hr  = new_time[11:8];
  assign nt_ms_min = new_time[7:4];
  assign nt_ls_min = new_time[3:0];

  // Decide whether the requested load is a legal BCD time for the active mode
  always_comb begin
    load_ok = (nt_ms_min <= 4'd5) && (nt_ls_min <= 4'd9);
`ifdef TWELVE_HOUR_EN
    if (!(((nt_ms_hr == 4'd0) && (nt_ls_hr != 4'd0) && (nt_ls_hr <= 4'd9)) ||
          ((nt_ms_hr == 4'd1) && (nt_ls_hr <= 4'd2)))) begin
      load_ok = 1'b0;
    end
`else
    if (!((nt_ms_hr <= 4'd1 && nt_ls_hr <= 4'd9) ||
          (nt_ms_hr == 4'd2 && nt_ls_hr <= 4'd3))) begin
      load_ok = 1'b0;
    end
`endif
  end

  // Compute the next time and pulse values; a load always beats an advance
  always_comb begin
    adv          = fast_watch ? one_second : one_minute;
    time_d       = time_q;
    hour_tick_d  = 1'b0;
    day_tick_d   = 1'b0;
    load_error_d = 1'b0;
    pm_d         = pm_q;
    if (load_new_time) begin
      if (load_ok) begin
        time_d = new_time;
      end else begin
        load_error_d = 1'b1;
      end
    end else if (adv) begin
      if (ls_min != 4'd9) begin
        time_d[3:0] = ls_min + 4'd1;
      end else begin
        time_d[3:0] = 4'd0;
        if (ms_min != 4'd5) begin
          time_d[7:4] = ms_min + 4'd1;
        end else begin
          time_d[7:4] = 4'd0;
          hour_tick_d = 1'b1;
`ifdef TWELVE_HOUR_EN
          if (ms_hr == 4'd1 && ls_hr == 4'd1) begin
            time_d[15:8] = 8'h12;
            pm_d         = ~pm_q;
            day_tick_d   = pm_q;
          end else if (ms_hr == 4'd1 && ls_hr == 4'd2) begin
            time_d[15:8] = 8'h01;
          end else if (ls_hr == 4'd9) begin
            time_d[15:8] = {ms_hr + 4'd1, 4'd0};
          end else begin
            time_d[11:8] = ls_hr + 4'd1;
          end
`else
          if (ms_hr == 4'd2 && ls_hr == 4'd3) begin
            time_d[15:8] = 8'h00;
            day_tick_d   = 1'b1;
          end else if (ls_hr == 4'd9) begin
            time_d[15:8] = {ms_hr + 4'd1, 4'd0};
          end else begin
            time_d[11:8] = ls_hr + 4'd1;
          end
`endif
        end
      end
    end
  end

  // Register time, meridiem flag and single-cycle pulses; reset is asynchronous
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      time_q     <= {INIT_HR, RESET_MIN};
      hour_tick  <= 1'b0;
      day_tick   <= 1'b0;
      load_error <= 1'b0;
      pm_q       <= 1'b0;
    end else begin
      time_q     <= time_d;
      hour_tick  <= hour_tick_d;
      day_tick   <= day_tick_d;
      load_error <= load_error_d;
      pm_q       <= pm_d;
    end
  end

  assign current_time = time_q;
`ifdef TWELVE_HOUR_EN
  assign pm = pm_q;
`endif

endmodule

// File: tb/tb_time_counter.sv
// tb_time_counter: scoreboard bench for time_counter in its default 24-hour build.
module tb_time_counter;

  logic        clk;
  logic        reset;
  logic        one_second;
  logic        one_minute;
  logic        fast_watch;
  logic        load_new_time;
  logic [15:0] new_time;
  logic [15:0] current_time;
  logic        hour_tick;
  logic        day_tick;
  logic        load_error;
`ifdef TWELVE_HOUR_EN
  logic        pm;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [15:0] t;
    logic        ht;
    logic        dt;
    logic        le;
  } exp_t;

  typedef struct packed {
    logic        os;
    logic        om;
    logic        fw;
    logic        ld;
    logic [15:0] nt;
    logic [15:0] et;
    logic        eh;
    logic        ed;
    logic        ee;
  } step_t;

  exp_t sb_q[$];

  time_counter dut (
    .clk           (clk),
    .reset         (reset),
    .one_second    (one_second),
    .one_minute    (one_minute),
    .fast_watch    (fast_watch),
    .load_new_time (load_new_time),
    .new_time      (new_time),
    .current_time  (current_time),
    .hour_tick     (hour_tick),
    .day_tick      (day_tick),
`ifdef TWELVE_HOUR_EN
    .pm            (pm),
`endif
    .load_error    (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one clock of stimulus, queue its expected result, return at the falling edge
  task automatic drive_cycle(input step_t s);
    one_second    = s.os;
    one_minute    = s.om;
    fast_watch    = s.fw;
    load_new_time = s.ld;
    new_time      = s.nt;
    sb_q.push_back('{t: s.et, ht: s.eh, dt: s.ed, le: s.ee});
    @(posedge clk);
    @(negedge clk);
    one_second    = 1'b0;
    one_minute    = 1'b0;
    load_new_time = 1'b0;
  endtask

  task automatic test_reset();
    step_t steps[7];
    exp_t  e;
    reset = 1'b0;
    one_second = 1'b0; one_minute = 1'b0; fast_watch = 1'b0;
    load_new_time = 1'b0; new_time = 16'h0000;
    #1;
    n_cmp++;
    if ({current_time, hour_tick, day_tick, load_error} !== {16'h0000, 3'b000}) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got time=%h ticks=%b%b%b, expected 0000 000",
               current_time, hour_tick, day_tick, load_error);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    //            os    om    fw    ld    nt        et        eh    ed    ee
    steps[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    steps[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0};
    steps[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0};
    steps[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0002, 1'b0, 1'b0, 1'b0};
    steps[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0003, 1'b0, 1'b0, 1'b0};
    steps[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0003, 1'b0, 1'b0, 1'b0};
    steps[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0003, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      drive_cycle(steps[i]);
      e = sb_q.pop_front();
      n_cmp++;
      if ({current_time, hour_tick, day_tick, load_error} !== e) begin
        n_fail++;
        $display("[TB] FAIL count_up step %0d: got time=%h ticks=%b%b%b, expected %h %b%b%b",
                 i, current_time, hour_tick, day_tick, load_error, e.t, e.ht, e.dt, e.le);
      end
    end
  endtask

  task automatic test_wrap();
    step_t steps[9];
    exp_t  e;
    steps[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0059, 16'h0059, 1'b0, 1'b0, 1'b0};
    steps[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0100, 1'b1, 1'b0, 1'b0};
    steps[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0100, 1'b0, 1'b0, 1'b0};
    steps[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0959, 16'h0959, 1'b0, 1'b0, 1'b0};
    steps[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1000, 1'b1, 1'b0, 1'b0};
    steps[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h2359, 16'h2359, 1'b0, 1'b0, 1'b0};
    steps[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h2359, 1'b0, 1'b0, 1'b0};
    steps[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0};
    steps[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      drive_cycle(steps[i]);
      e = sb_q.pop_front();
      n_cmp++;
      if ({current_time, hour_tick, day_tick, load_error} !== e) begin
        n_fail++;
        $display("[TB] FAIL wrap step %0d: got time=%h ticks=%b%b%b, expected %h %b%b%b",
                 i, current_time, hour_tick, day_tick, load_error, e.t, e.ht, e.dt, e.le);
      end
    end
  endtask

  task automatic test_load_error();
    step_t steps[8];
    exp_t  e;
    steps[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h2460, 16'h0000, 1'b0, 1'b0, 1'b1};
    steps[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    steps[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h1275, 16'h0000, 1'b0, 1'b0, 1'b1};
    steps[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    steps[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h1A00, 16'h0000, 1'b0, 1'b0, 1'b1};
    steps[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h2400, 16'h0000, 1'b0, 1'b0, 1'b1};
    steps[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h2359, 16'h2359, 1'b0, 1'b0, 1'b0};
    steps[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h3000, 16'h2359, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      drive_cycle(steps[i]);
      e = sb_q.pop_front();
      n_cmp++;
      if ({current_time, hour_tick, day_tick, load_error} !== e) begin
        n_fail++;
        $display("[TB] FAIL load_error step %0d: got time=%h ticks=%b%b%b, expected %h %b%b%b",
                 i, current_time, hour_tick, day_tick, load_error, e.t, e.ht, e.dt, e.le);
      end
    end
  endtask

  task automatic test_fast_watch();
    step_t steps[8];
    exp_t  e;
    steps[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0958, 16'h0958, 1'b0, 1'b0, 1'b0};
    steps[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0959, 1'b0, 1'b0, 1'b0};
    steps[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1000, 1'b1, 1'b0, 1'b0};
    steps[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1000, 1'b0, 1'b0, 1'b0};
    steps[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1000, 1'b0, 1'b0, 1'b0};
    steps[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1000, 1'b0, 1'b0, 1'b0};
    steps[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1001, 1'b0, 1'b0, 1'b0};
    steps[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1002, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      drive_cycle(steps[i]);
      e = sb_q.pop_front();
      n_cmp++;
      if ({current_time, hour_tick, day_tick, load_error} !== e) begin
        n_fail++;
        $display("[TB] FAIL fast_watch step %0d: got time=%h ticks=%b%b%b, expected %h %b%b%b",
                 i, current_time, hour_tick, day_tick, load_error, e.t, e.ht, e.dt, e.le);
      end
    end
    fast_watch = 1'b0;
  endtask

  task automatic test_priority();
    step_t steps[4];
    exp_t  e;
    steps[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h1030, 16'h1030, 1'b0, 1'b0, 1'b0};
    steps[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1030, 1'b0, 1'b0, 1'b0};
    steps[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1031, 1'b0, 1'b0, 1'b0};
    steps[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h1030, 16'h1030, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive_cycle(steps[i]);
      e = sb_q.pop_front();
      n_cmp++;
      if ({current_time, hour_tick, day_tick, load_error} !== e) begin
        n_fail++;
        $display("[TB] FAIL priority step %0d: got time=%h ticks=%b%b%b, expected %h %b%b%b",
                 i, current_time, hour_tick, day_tick, load_error, e.t, e.ht, e.dt, e.le);
      end
    end
    fast_watch = 1'b0;
  endtask

  task automatic test_async_reset();
    step_t steps[3];
    exp_t  e;
    steps[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0815, 16'h0815, 1'b0, 1'b0, 1'b0};
    steps[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    steps[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0};
    drive_cycle(steps[0]);
    e = sb_q.pop_front();
    n_cmp++;
    if (current_time !== e.t) begin
      n_fail++;
      $display("[TB] FAIL async_preload: got time=%h, expected %h", current_time, e.t);
    end
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    n_cmp++;
    if (current_time !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL async_reset_midcycle: got time=%h, expected 0000", current_time);
    end
    @(negedge clk);
    one_minute = 1'b1;
    @(posedge clk);
    @(negedge clk);
    one_minute = 1'b0;
    n_cmp++;
    if ({current_time, hour_tick} !== {16'h0000, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL strobe_in_reset: got time=%h ht=%b, expected 0000 0",
               current_time, hour_tick);
    end
    reset = 1'b1;
    for (int i = 1; i < 3; i++) begin
      drive_cycle(steps[i]);
      e = sb_q.pop_front();
      n_cmp++;
      if ({current_time, hour_tick, day_tick, load_error} !== e) begin
        n_fail++;
        $display("[TB] FAIL after_reset step %0d: got time=%h ticks=%b%b%b, expected %h %b%b%b",
                 i, current_time, hour_tick, day_tick, load_error, e.t, e.ht, e.dt, e.le);
      end
    end
  endtask

  // Bound the whole run so a stuck simulation still ends with a report
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Run every scenario in order, then report totals
  initial begin
    test_reset();
    test_wrap();
    test_load_error();
    test_fast_watch();
    test_priority();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
